picosoc_iomem_initiator: RTL
============================

PICOSOC_IOMEM_INITIATOR -- requirements
Module: picosoc_iomem_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum cycles to wait for iomem_ready; 0 disables timeout.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on posedge clk.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: client request present.
REQ-005 SHALL have port req_ready, output, 1: block can accept a request.
REQ-006 SHALL have port req_addr, input, 32: target byte address.
REQ-007 SHALL have port req_wdata, input, 32: write data.
REQ-008 SHALL have port req_wstrb, input, 4: byte strobes; 0 means read.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32: read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_timeout, output, 1: completion was a timeout, valid with rsp_valid.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port iomem_valid, output, 1: bus request to responder.
REQ-014 SHALL have port iomem_wstrb, output, 4: bus strobes.
REQ-015 SHALL have port iomem_addr, output, 32: bus address.
REQ-016 SHALL have port iomem_wdata, output, 32: bus write data.
REQ-017 SHALL have port iomem_rdata, input, 32: responder read data.
REQ-018 SHALL have port iomem_ready, input, 1: responder completion.

Function
REQ-019 SHALL implement states IDLE, BUS, RESP; one transaction outstanding at most.
REQ-020 SHALL drive req_ready high only in IDLE (registered state decode; no combinational path from req_valid).
REQ-021 SHALL, in IDLE with req_valid high, capture addr/wdata/wstrb and enter BUS on the next edge.
REQ-022 SHALL hold iomem_valid high and iomem_addr/wdata/wstrb constant throughout BUS.
REQ-023 SHALL, in BUS on a cycle with iomem_ready high, capture iomem_rdata into rsp_rdata, clear rsp_timeout, and enter RESP.
REQ-024 SHALL capture iomem_rdata as presented for writes too (responders return 0 on writes).
REQ-025 SHALL count BUS cycles from 1; when the count reaches TIMEOUT_CYCLES with iomem_ready low, enter RESP with rsp_rdata=0, rsp_timeout=1.
REQ-026 SHALL give iomem_ready priority over timeout when both occur on the same cycle.
REQ-027 SHALL size the cycle counter to hold TIMEOUT_CYCLES without wrap; counter cleared on entry to BUS.
REQ-028 SHALL, with TIMEOUT_CYCLES=0, wait indefinitely in BUS.
REQ-029 SHALL drive iomem_valid low in RESP and IDLE; iomem_ready ignored outside BUS (responders may hold ready high one extra cycle).
REQ-030 SHALL assert rsp_valid for exactly the one RESP cycle, then return to IDLE; no response backpressure.
REQ-031 SHALL hold rsp_rdata and rsp_timeout stable after RESP until the next completion.
REQ-032 SHALL give minimum request-to-rsp_valid latency of 3 cycles (accept edge, BUS with ready seen, RESP), and accept the next request the cycle after RESP.
REQ-033 SHALL drive iomem_addr/wdata/wstrb to 0 outside BUS.

Reset
REQ-034 SHALL, while resetn is low at a clock edge, enter IDLE; iomem_valid=0, iomem_addr/wdata/wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0, counter=0.
REQ-035 SHALL, on reset mid-transaction (BUS or RESP), abandon it with no rsp_valid; iomem_valid low from the first edge with resetn low.
REQ-036 SHALL keep req_ready low while resetn is low.

Verification
REQ-037 Read: req addr=0x0200_0000, wstrb=0; responder returns 0x1234_5678 with ready 1 cycle after valid -> rsp_valid 1 cycle, rsp_rdata=0x1234_5678, rsp_timeout=0, latency 3 cycles.
REQ-038 Write: addr=0x0200_0008, wdata=1, wstrb=0xF; responder holds ready high 2 cycles -> exactly one rsp_valid, iomem_valid low in RESP, second ready cycle ignored.
REQ-039 Timeout: TIMEOUT_CYCLES=4, responder never ready -> iomem_valid high exactly 4 cycles, rsp_valid with rsp_timeout=1, rsp_rdata=0.
REQ-040 Tie: TIMEOUT_CYCLES=4, ready first high on 4th BUS cycle with rdata=0xA5 -> rsp_timeout=0, rsp_rdata=0xA5.
REQ-041 Back-to-back: req_valid held high for 3 requests -> req_ready high only in IDLE, three rsp_valid pulses, bus fields stable during each BUS.
REQ-042 Reset mid-BUS: resetn low 1 cycle on 2nd BUS cycle -> iomem_valid 0 next cycle, no rsp_valid, req_ready high after resetn returns high.

Source files
------------

// File: rtl/picosoc_iomem_initiator.sv
// Single-outstanding initiator for the PicoSoC iomem bus.
// Accepts one client request at a time, drives it onto iomem, waits for
// iomem_ready (optionally bounded by TIMEOUT_CYCLES), then emits a one-cycle
// completion pulse. All outputs except req_ready/busy come straight from flops.
//
//   state | meaning
//   IDLE  | no transaction; req_ready high, bus fields parked at 0
//   BUS   | iomem_valid high, bus fields held, waiting for ready or timeout
//   RESP  | rsp_valid high for this one cycle; iomem_valid already low
module picosoc_iomem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        iomem_valid,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    input  logic        iomem_ready
);

    // Counter must represent TIMEOUT_CYCLES itself, so size for value+1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              iomem_valid_q, iomem_valid_d;
    logic [31:0]       iomem_addr_q, iomem_addr_d;
    logic [31:0]       iomem_wdata_q, iomem_wdata_d;
    logic [3:0]        iomem_wstrb_q, iomem_wstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_inc       = cnt_q + 1'b1;
        iomem_valid_d = iomem_valid_q;
        iomem_addr_d  = iomem_addr_q;
        iomem_wdata_d = iomem_wdata_q;
        iomem_wstrb_d = iomem_wstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d       = ST_BUS;
                    cnt_d         = '0;
                    iomem_valid_d = 1'b1;
                    iomem_addr_d  = req_addr;
                    iomem_wdata_d = req_wdata;
                    iomem_wstrb_d = req_wstrb;
                end
            end
            ST_BUS: begin
                // cnt_inc is the 1-based index of the current BUS cycle.
                // A ready on the terminal cycle still counts as a completion.
                if (iomem_ready) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = iomem_rdata;
                    rsp_timeout_d = 1'b0;
                end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_VAL)) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_inc;
                end
                if (state_d == ST_RESP) begin
                    cnt_d         = '0;
                    iomem_valid_d = 1'b0;
                    iomem_addr_d  = '0;
                    iomem_wdata_d = '0;
                    iomem_wstrb_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d       = ST_IDLE;
                cnt_d         = '0;
                iomem_valid_d = 1'b0;
                iomem_addr_d  = '0;
                iomem_wdata_d = '0;
                iomem_wstrb_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            iomem_valid_q <= 1'b0;
            iomem_addr_q  <= '0;
            iomem_wdata_q <= '0;
            iomem_wstrb_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            iomem_valid_q <= iomem_valid_d;
            iomem_addr_q  <= iomem_addr_d;
            iomem_wdata_q <= iomem_wdata_d;
            iomem_wstrb_q <= iomem_wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // req_ready is a pure decode of the registered state, gated off in reset.
    assign req_ready   = resetn && (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign iomem_valid = iomem_valid_q;
    assign iomem_addr  = iomem_addr_q;
    assign iomem_wdata = iomem_wdata_q;
    assign iomem_wstrb = iomem_wstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
